// File: rtl/pipeline_ctrl.sv
// pipeline_ctrl -- hazard / stall / flush controller for a 5-stage in-order pipeline.
//
// Ports:
//   clk          rising-edge clock for all state
//   rst_n        asynchronous active-low reset
//   hz_stall     load-use hazard flagged by the decode-stage hazard detector
//   br_taken     branch/jump redirect resolved in EX
//   imem_ready   instruction fetch data valid this cycle
//   dmem_req     MEM stage holds a load/store this cycle
//   dmem_ready   data memory completes the MEM access this cycle
//   pc_we        PC register write enable
//   if_id_we     IF/ID register write enable
//   if_id_flush  IF/ID register loads a NOP
//   id_ex_bubble ID/EX register loads a NOP
//   ex_mem_we    EX/MEM and MEM/WB register write enable
//   state        current FSM state (RUN=0, LDSTALL=1, FLUSH=2, MWAIT=3)
//   stall_cnt    count of frozen or stalled cycles
//   flush_cnt    count of accepted redirects
//
// Build option: define PIPELINE_CTRL_PERF_EN to enable the saturating
// performance counters; otherwise both counters read as constant zero and
// no counter flops exist.
//
// Control outputs are combinational from the current state and inputs and
// are held inactive while rst_n is low.

module pipeline_ctrl (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        hz_stall,
    input  logic        br_taken,
    input  logic        imem_ready,
    input  logic        dmem_req,
    input  logic        dmem_ready,
    output logic        pc_we,
    output logic        if_id_we,
    output logic        if_id_flush,
    output logic        id_ex_bubble,
    output logic        ex_mem_we,
    output logic [1:0]  state,
    output logic [31:0] stall_cnt,
    output logic [31:0] flush_cnt
);

    typedef enum logic [1:0] {
        RUN     = 2'd0,
        LDSTALL = 2'd1,
        FLUSH   = 2'd2,
        MWAIT   = 2'd3
    } state_e;

    state_e state_q, state_d;
    state_e ret_q, ret_d;
    state_e eff_state;

    // Set once a bubble has been inserted for the hazard currently reported;
    // cleared when hz_stall drops. Keeps a long-held hz_stall (the held IF/ID
    // pair, or freeze cycles in between) from producing a second bubble.
    logic served_q, served_d;

    logic freeze;
    logic br_acc;
    logic pc_we_c, if_id_we_c, if_id_flush_c, id_ex_bubble_c, ex_mem_we_c;

    assign freeze = (dmem_req & ~dmem_ready) | ~imem_ready;

    // MWAIT behaves as the state it interrupted once the freeze lifts.
    assign eff_state = (state_q == MWAIT) ? ret_q : state_q;

    always_comb begin
        state_d        = state_q;
        ret_d          = ret_q;
        served_d       = served_q & hz_stall;
        br_acc         = 1'b0;
        pc_we_c        = 1'b0;
        if_id_we_c     = 1'b0;
        if_id_flush_c  = 1'b0;
        id_ex_bubble_c = 1'b0;
        ex_mem_we_c    = 1'b0;

        if (freeze) begin
            if (state_q != MWAIT) begin
                ret_d   = state_q;
                state_d = MWAIT;
            end
        end else begin
            case (eff_state)
                FLUSH: begin
                    pc_we_c       = 1'b1;
                    if_id_we_c    = 1'b1;
                    if_id_flush_c = 1'b1;
                    ex_mem_we_c   = 1'b1;
                    if (br_taken) begin
                        id_ex_bubble_c = 1'b1;
                        br_acc         = 1'b1;
                        state_d        = FLUSH;
                    end else begin
                        state_d = RUN;
                    end
                end
                default: begin
                    // RUN and LDSTALL; LDSTALL never looks at hz_stall.
                    if (br_taken) begin
                        pc_we_c        = 1'b1;
                        if_id_flush_c  = 1'b1;
                        id_ex_bubble_c = 1'b1;
                        ex_mem_we_c    = 1'b1;
                        br_acc         = 1'b1;
                        state_d        = FLUSH;
                    end else if ((eff_state == RUN) && hz_stall && !served_q) begin
                        id_ex_bubble_c = 1'b1;
                        ex_mem_we_c    = 1'b1;
                        served_d       = 1'b1;
                        state_d        = LDSTALL;
                    end else begin
                        pc_we_c     = 1'b1;
                        if_id_we_c  = 1'b1;
                        ex_mem_we_c = 1'b1;
                        state_d     = RUN;
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= RUN;
            ret_q    <= RUN;
            served_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            ret_q    <= ret_d;
            served_q <= served_d;
        end
    end

    assign pc_we        = rst_n & pc_we_c;
    assign if_id_we     = rst_n & if_id_we_c;
    assign if_id_flush  = rst_n & if_id_flush_c;
    assign id_ex_bubble = rst_n & id_ex_bubble_c;
    assign ex_mem_we    = rst_n & ex_mem_we_c;
    assign state        = state_q;

`ifdef PIPELINE_CTRL_PERF_EN
    logic [31:0] stall_cnt_q;
    logic [31:0] flush_cnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            if (!pc_we_c && (stall_cnt_q != '1)) begin
                stall_cnt_q <= stall_cnt_q + 32'd1;
            end
            if (br_acc && (flush_cnt_q != '1)) begin
                flush_cnt_q <= flush_cnt_q + 32'd1;
            end
        end
    end

    assign stall_cnt = stall_cnt_q;
    assign flush_cnt = flush_cnt_q;
`else
    assign stall_cnt = '0;
    assign flush_cnt = '0;
`endif

endmodule
